// File: rtl/fpu_pack_pipe.sv
// Two-stage FPU pack: round then IEEE-754 pack with valid/ready flow control.
// FPU_PACK_ROUND_EN selects round-to-nearest-even; undefined truncates.
module fpu_pack_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_s,
  input  logic [EXP_W+1:0]       in_e,
  input  logic [MAN_W+3:0]       in_m,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_z,
  output logic [2:0]             out_flags,
  output logic [TAG_W-1:0]       out_tag
);

  localparam int EW   = EXP_W + 2;
  localparam int BIAS = 2**(EXP_W-1) - 1;
  localparam logic signed [EW-1:0] EMIN = EW'(1 - BIAS);
  localparam logic signed [EW-1:0] EMAX = EW'(BIAS);

  typedef struct packed {
    logic             s;
    logic [EW-1:0]    e;
    logic [MAN_W:0]   m;
    logic             ix;
    logic [TAG_W-1:0] tag;
  } rnd_t;

  logic s1_valid, s2_valid;
  logic s2_adv, s1_load, s2_load;
  rnd_t s1_d, s1_q;

  assign s2_adv   = !s2_valid | out_ready;
  assign in_ready = !s1_valid | s2_adv;
  assign s1_load  = in_valid & in_ready;
  assign s2_load  = s1_valid & s2_adv;

`ifdef FPU_PACK_ROUND_EN
  logic             rup;
  logic [MAN_W+1:0] sum;

  assign rup = in_m[2] & (in_m[1] | in_m[0] | in_m[3]);
  assign sum = {1'b0, in_m[MAN_W+3:3]}
             + {{(MAN_W+1){1'b0}}, rup};
`endif

  always_comb begin
    s1_d     = '0;
    s1_d.s   = in_s;
    s1_d.tag = in_tag;
    s1_d.ix  = |in_m[2:0];
`ifdef FPU_PACK_ROUND_EN
    if (sum[MAN_W+1]) begin
      s1_d.m = {1'b1, {MAN_W{1'b0}}};
      s1_d.e = in_e + EW'(1);
    end else begin
      s1_d.m = sum[MAN_W:0];
      s1_d.e = in_e;
    end
`else
    s1_d.m = in_m[MAN_W+3:3];
    s1_d.e = in_e;
`endif
  end

  logic               ovf, unf, at_min, sub, zs;
  logic [EXP_W-1:0]   eb;
  logic [EXP_W+MAN_W:0] p_z;
  logic [2:0]         p_f;

  assign ovf    = $signed(s1_q.e) > EMAX;
  assign unf    = $signed(s1_q.e) < EMIN;
  assign at_min = $signed(s1_q.e) == EMIN;
  assign sub    = at_min & !s1_q.m[MAN_W];
  assign eb     = s1_q.e[EXP_W-1:0] + EXP_W'(BIAS);
  // exact zero at EMIN always packs as +0
  assign zs     = s1_q.s & !(at_min & (s1_q.m == '0));

  always_comb begin
    p_z = '0;
    p_f = '0;
    unique case (1'b1)
      ovf: begin
        p_z = {s1_q.s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        p_f = 3'b101;
      end
      unf: begin
        p_z = '0;
        p_f = 3'b011;
      end
      sub: begin
        p_z = {zs, {EXP_W{1'b0}}, s1_q.m[MAN_W-1:0]};
        p_f = {1'b0, s1_q.ix, s1_q.ix};
      end
      default: begin
        p_z = {zs, eb, s1_q.m[MAN_W-1:0]};
        p_f = {2'b00, s1_q.ix};
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      s1_q      <= '0;
      out_z     <= '0;
      out_flags <= '0;
      out_tag   <= '0;
    end else begin
      if (s1_load) s1_q <= s1_d;
      if (s1_load)      s1_valid <= 1'b1;
      else if (s2_load) s1_valid <= 1'b0;
      if (s2_load) begin
        out_z     <= p_z;
        out_flags <= p_f;
        out_tag   <= s1_q.tag;
      end
      if (s2_load)        s2_valid <= 1'b1;
      else if (out_ready) s2_valid <= 1'b0;
    end
  end

  assign out_valid = s2_valid;

endmodule
